// File: rtl/iiitb_sdm_pkg.sv
// Shared constants for the sequence-detector event logger.
package iiitb_sdm_pkg;
   localparam int DEPTH = 8;
   localparam int TS_W  = 16;
   localparam int CNT_W = 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
endpackage

// File: rtl/iiitb_sync_fifo.sv
// Synchronous FIFO with combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module iiitb_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        din,
   output logic                     full,
   input  logic                     pop,
   output logic                     valid,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       cnt;
   logic              do_push;
   logic              do_pop;

   assign valid   = (cnt != '0);
   assign full    = (cnt == FULL_LVL);
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   assign level   = cnt;

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage write; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/iiitb_sdm_evlog.sv
// Event logger: timestamps detector pulses into a FIFO and keeps
// event / drop statistics with a sticky overflow flag.
module iiitb_sdm_evlog
   import iiitb_sdm_pkg::*;
#(
   parameter int DEPTH = iiitb_sdm_pkg::DEPTH,
   parameter int TS_W  = iiitb_sdm_pkg::TS_W,
   parameter int CNT_W = iiitb_sdm_pkg::CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     det,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [TS_W-1:0]          rd_data,
   output logic [CNT_W-1:0]         ev_count,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);
   logic [TS_W-1:0] ts;
   logic            ev;
   logic            full;
   logic            drop;
   logic            push;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A full FIFO always presents valid, so only rd_ready decides whether
   // the head frees a slot for this cycle's event.
   assign ev   = en & det;
   assign drop = ev & full & ~rd_ready;
   assign push = ev & ~drop;

   // Free-running timestamp, advancing only while enabled.
   always_ff @(posedge clk) begin
      if (reset)   ts <= '0;
      else if (en) ts <= ts + 1'b1;
   end

   // Event counter wraps; drop counter saturates; overflow is sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         ev_count   <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (ev)   ev_count   <= ev_count + 1'b1;
         if (drop) drop_count <= sat_inc(drop_count);
         if (drop) overflow   <= 1'b1;
      end
   end

   iiitb_sync_fifo #(
      .DATA_W(TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .din  (ts),
      .full (full),
      .pop  (rd_ready),
      .valid(rd_valid),
      .dout (rd_data),
      .level(level)
   );
endmodule

// File: doc/iiitb_sdm_evlog.md
IIITB_SDM_EVLOG -- requirements
Module: iiitb_sdm_evlog

Interface
- REQ-001: Parameter DEPTH, default 8, sets the number of FIFO entries (power of two, minimum 2).
- REQ-002: Parameter TS_W, default 16, sets the timestamp width in bits.
- REQ-003: Parameter CNT_W, default 8, sets the width of the event and drop counters.
- REQ-004: Port clk, input, 1 bit: the single clock; all logic is rising-edge clk.
- REQ-005: Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-006: Port en, input, 1 bit: when high, the timestamp runs and events are captured.
- REQ-007: Port det, input, 1 bit: detection pulse, driven by the y output of the sequence detector.
- REQ-008: Port rd_valid, output, 1 bit: the FIFO head entry is available.
- REQ-009: Port rd_ready, input, 1 bit: the consumer accepts the head entry.
- REQ-010: Port rd_data, output, TS_W bits: timestamp of the head entry.
- REQ-011: Port ev_count, output, CNT_W bits: total events seen.
- REQ-012: Port drop_count, output, CNT_W bits: events lost to a full FIFO.
- REQ-013: Port overflow, output, 1 bit: sticky flag, set on the first dropped event.
- REQ-014: Port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
- REQ-015: A free-running TS_W timestamp register shall increment by 1 each cycle while en=1, hold while en=0, and wrap from 2^TS_W-1 to 0.
- REQ-016: Each cycle with det=1 and en=1 shall count as exactly one event; consecutive high cycles are separate events; det is ignored while en=0.
- REQ-017: On an event, the pre-increment timestamp value for that cycle shall be pushed into the FIFO.
- REQ-018: A pushed entry shall be visible on rd_data with rd_valid=1 on the next cycle (1-cycle latency when the FIFO was empty).
- REQ-019: A pop shall occur exactly in a cycle with rd_valid=1 and rd_ready=1; rd_data shall stay stable while rd_valid=1 and rd_ready=0.
- REQ-020: rd_valid shall be 1 if and only if level is not 0; entries shall leave in push order.
- REQ-021: If the FIFO is full and a pop occurs in the same cycle as an event, the push shall be accepted and level shall stay at DEPTH.
- REQ-022: If the FIFO is full and no pop occurs, the event shall be dropped, drop_count shall increment and overflow shall set.
- REQ-023: If the FIFO is empty and an event occurs, the pop shall not bypass; rd_valid shall assert the following cycle.
- REQ-024: ev_count shall increment on every event, accepted or dropped, and wrap modulo 2^CNT_W.
- REQ-025: drop_count shall saturate at 2^CNT_W-1.
- REQ-026: overflow shall clear only on reset.
- REQ-027: Read and write pointers shall be clog2(DEPTH) bits wide and wrap naturally.

Reset
- REQ-028: While reset=1 at a clk edge, the following shall clear: timestamp=0, level=0, pointers=0, rd_valid=0, ev_count=0, drop_count=0, overflow=0.
- REQ-029: reset shall take priority over det, en and rd_ready in the same cycle.
- REQ-030: FIFO entries present when reset is asserted (reset mid-operation) shall be discarded.
- REQ-031: FIFO storage RAM shall not be reset.
- REQ-032: rd_data shall be don't-care while rd_valid=0.

Structure
- REQ-033: Constants DEPTH, TS_W and CNT_W, and the derived pointer width, shall live in the shared package iiitb_sdm_pkg.
- REQ-034: The FIFO shall be the sub-module iiitb_sync_fifo, parameterized by width and depth, with push/full and pop/valid ports.
- REQ-035: The timestamp, counters and drop logic shall remain in the top module.

Verification
- REQ-036: Reset, then en=1 and det=1 at timestamp=5 -> rd_valid=1 next cycle, rd_data=5, ev_count=1.
- REQ-037: det=1 for 3 consecutive cycles at timestamps 10, 11, 12 with rd_ready=1 -> three pops returning 10, 11, 12 in order, ev_count=3.
- REQ-038: rd_ready=0 and 10 events at DEPTH=8 -> level=8, drop_count=2, overflow=1, ev_count=10; then drain -> the 8 oldest timestamps in order.
- REQ-039: FIFO full, then det=1 and rd_ready=1 in the same cycle -> level stays 8, drop_count unchanged, the new timestamp appears last.
- REQ-040: 3 entries queued, then reset=1 for one cycle -> level=0, rd_valid=0, all counters 0, timestamp restarts at 0.
- REQ-041: Drive din pattern 0,1,0,1,0,1,0,0,1,0,0 into the 1010 detector feeding det -> two events logged, with timestamps matching the y pulses.
